// File: rtl/lab_config_sequencer.sv
// Serial configuration loader: deserialises a bit stream into a shadow array and commits it atomically.
// Optional per-word even parity is enabled by defining LAB_CONFIG_PARITY_EN.
module lab_config_sequencer #(
  parameter int NUM_MACROCELLS = 16,
  parameter int CONFIG_WIDTH   = 13
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic                                   bit_data,
  input  logic                                   bit_valid,
  output logic                                   bit_ready,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   error,
  output logic [NUM_MACROCELLS*CONFIG_WIDTH-1:0] config_active
);

  localparam int TOTAL = NUM_MACROCELLS * CONFIG_WIDTH;
  localparam int BW    = $clog2(CONFIG_WIDTH);
  localparam int WW    = $clog2(NUM_MACROCELLS);
  localparam int IW    = $clog2(TOTAL);

`ifdef LAB_CONFIG_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PARITY = 2'd2, COMMIT = 2'd3} state_t;
  logic parity_acc;
  logic parity_bad;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, COMMIT = 2'd3} state_t;
`endif

  state_t          state;
  state_t          next_state;
  logic [BW-1:0]   bit_cnt;
  logic [WW-1:0]   word_cnt;
  logic [TOTAL-1:0] shadow;
  logic [IW-1:0]   bit_idx;
  logic            take;
  logic            bit_last;
  logic            word_last;

  // Handshake qualifiers and shadow write index
  always_comb begin
    take      = bit_valid && bit_ready && !abort;
    bit_last  = (bit_cnt == BW'(CONFIG_WIDTH - 1));
    word_last = (word_cnt == WW'(NUM_MACROCELLS - 1));
    bit_idx   = IW'(word_cnt) * IW'(CONFIG_WIDTH) + IW'(bit_cnt);
`ifdef LAB_CONFIG_PARITY_EN
    parity_bad = parity_acc ^ bit_data;
`endif
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = LOAD;
        else       next_state = IDLE;
      end
      LOAD: begin
        if (abort) begin
          next_state = IDLE;
        end else if (take && bit_last) begin
`ifdef LAB_CONFIG_PARITY_EN
          next_state = PARITY;
`else
          next_state = word_last ? COMMIT : LOAD;
`endif
        end else begin
          next_state = LOAD;
        end
      end
`ifdef LAB_CONFIG_PARITY_EN
      PARITY: begin
        if (abort)           next_state = IDLE;
        else if (!take)      next_state = PARITY;
        else if (parity_bad) next_state = IDLE;
        else                 next_state = word_last ? COMMIT : LOAD;
      end
`endif
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, counters, shadow array and registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      word_cnt      <= '0;
      shadow        <= '1;
      config_active <= '1;
      bit_ready     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
`ifdef LAB_CONFIG_PARITY_EN
      parity_acc    <= 1'b0;
`endif
    end else begin
      state     <= next_state;
      bit_ready <= (next_state == LOAD)
`ifdef LAB_CONFIG_PARITY_EN
                   || (next_state == PARITY)
`endif
                   ;
      busy      <= (next_state != IDLE);
      done      <= (state == COMMIT);
      case (state)
        IDLE: begin
          if (start) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
            error    <= 1'b0;
`ifdef LAB_CONFIG_PARITY_EN
            parity_acc <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (take) begin
            shadow[bit_idx] <= bit_data;
`ifdef LAB_CONFIG_PARITY_EN
            parity_acc <= parity_acc ^ bit_data;
`endif
            if (bit_last) begin
              bit_cnt <= '0;
`ifndef LAB_CONFIG_PARITY_EN
              word_cnt <= word_cnt + WW'(1);
`endif
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
`ifdef LAB_CONFIG_PARITY_EN
        PARITY: begin
          if (take) begin
            parity_acc <= 1'b0;
            if (parity_bad) error    <= 1'b1;
            else            word_cnt <= word_cnt + WW'(1);
          end
        end
`endif
        COMMIT:  config_active <= shadow;
        default: ;
      endcase
    end
  end

endmodule
